// File: rtl/pipe_pkg.sv
// Shared definitions for the flopr_pipe pipeline register family.
package pipe_pkg;

   // Default geometry: one 9-bit datapath boundary, two stages deep.
   localparam int DEF_WIDTH = 9;
   localparam int DEF_DEPTH = 2;

   // Width of a counter able to hold 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : pipe_pkg

// File: rtl/flopr_pipe_stage.sv
// One pipeline stage: data plus valid flag, with load, synchronous flush
// and asynchronous reset.
module flopr_pipe_stage
   import pipe_pkg::*;
#(
   parameter int             WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter bit             FLUSH_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Next-state selection: flush beats load, otherwise hold.
   always_comb begin
      // NOTE: defaulting every output of a combinational block to its held value
      // first means no path leaves it unassigned, so no latch is inferred.
      data_d  = data_q;
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
         if (FLUSH_DATA) data_d = RST_VAL;
      end else if (load_i) begin
         valid_d = valid_i;
         data_d  = data_i;
      end
   end

   // Stage register with asynchronous reset to an empty, RST_VAL-filled stage.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values and stage ordering cannot create a race.
      if (!reset_n) begin
         data_q  <= RST_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule : flopr_pipe_stage

// File: rtl/flopr_pipe.sv
// Multi-stage pipeline register with per-stage valid, flush, back-pressure,
// optional bubble collapse and a registered occupancy count.
module flopr_pipe
   import pipe_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter int               DEPTH      = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL    = '0,
   parameter bit               COLLAPSE   = 1'b0,
   parameter bit               FLUSH_DATA = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable_half,
   input  logic                          stall,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              d,
   input  logic                          d_valid,
   output logic                          d_ready,
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } pipe_stage_t;

   pipe_stage_t      stage_w [DEPTH];
   logic [DEPTH-1:0] move;
   logic [DEPTH-1:0] valid_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             hold;

   assign hold = enable_half;

   // Per-stage load enables. In collapse mode a stage may load when it is
   // empty or when its own contents leave this cycle, so bubbles are filled
   // and an empty output stage never blocks.
   always_comb begin
      logic go;
      move = '0;
      if (COLLAPSE) begin
         go = !hold && (!stall || !stage_w[DEPTH-1].valid);
         move[DEPTH-1] = go;
         for (int i = DEPTH - 2; i >= 0; i--) begin
            go      = !hold && (!stage_w[i].valid || go);
            move[i] = go;
         end
      end else begin
         go   = !stall && !hold;
         move = {DEPTH{go}};
      end
   end

   // Next valid pattern, mirrored here so occupancy updates on the same edge.
   always_comb begin
      valid_d = '0;
      if (!flush) begin
         valid_d[0] = move[0] ? d_valid : stage_w[0].valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = move[i] ? stage_w[i-1].valid : stage_w[i].valid;
         end
      end
   end

   // Popcount of the next valid pattern.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_d = occ_d + OCC_W'(valid_d[i]);
      end
   end

   // Registered occupancy, cleared by reset together with the valid flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) occ_q <= '0;
      else          occ_q <= occ_d;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [WIDTH-1:0] up_data;
      logic             up_valid;
      logic [WIDTH-1:0] st_data;
      logic             st_valid;

      if (g == 0) begin : g_head
         assign up_data  = d;
         assign up_valid = d_valid;
      end else begin : g_body
         assign up_data  = stage_w[g-1].data;
         assign up_valid = stage_w[g-1].valid;
      end

      flopr_pipe_stage #(
         .WIDTH      (WIDTH),
         .RST_VAL    (RST_VAL),
         .FLUSH_DATA (FLUSH_DATA)
      ) u_stage (
         .clk     (clk),
         .reset_n (reset_n),
         .load_i  (move[g]),
         .flush_i (flush),
         .data_i  (up_data),
         .valid_i (up_valid),
         .data_o  (st_data),
         .valid_o (st_valid)
      );

      assign stage_w[g] = '{valid: st_valid, data: st_data};
   end

   // Input is refused during reset and flush; otherwise stage 0 decides.
   assign d_ready   = move[0] && !flush && reset_n;
   assign q         = stage_w[DEPTH-1].data;
   assign q_valid   = stage_w[DEPTH-1].valid;
   assign occupancy = occ_q;

endmodule : flopr_pipe

// File: tb/tb_flopr_pipe.sv
// Self-checking bench for flopr_pipe: a freeze-mode instance is tracked by an
// in-order scoreboard plus directed checks; a collapse-mode instance shares
// the same stimulus and is checked directly during the bubble sequence.
module tb_flopr_pipe;

   logic       clk;
   logic       reset_n;
   logic       enable_half;
   logic       stall;
   logic       flush;
   logic [8:0] d;
   logic       d_valid;

   logic       d_ready,  q_valid;
   logic [8:0] q;
   logic [1:0] occupancy;

   logic       c_d_ready, c_q_valid;
   logic [8:0] c_q;
   logic [1:0] c_occupancy;

   int         total = 0;
   int         bad   = 0;
   logic [8:0] sb [$];
   logic       rdy, crdy;

   flopr_pipe #(
      .WIDTH(9), .DEPTH(3), .RST_VAL(9'h000), .COLLAPSE(1'b0), .FLUSH_DATA(1'b1)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .enable_half(enable_half), .stall(stall),
      .flush(flush), .d(d), .d_valid(d_valid), .d_ready(d_ready),
      .q(q), .q_valid(q_valid), .occupancy(occupancy)
   );

   flopr_pipe #(
      .WIDTH(9), .DEPTH(3), .RST_VAL(9'h000), .COLLAPSE(1'b1), .FLUSH_DATA(1'b1)
   ) u_col (
      .clk(clk), .reset_n(reset_n), .enable_half(enable_half), .stall(stall),
      .flush(flush), .d(d), .d_valid(d_valid), .d_ready(c_d_ready),
      .q(c_q), .q_valid(c_q_valid), .occupancy(c_occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, settle, update the scoreboard from the
   // handshakes that will fire on the coming edge, then step past the edge.
   task automatic cycle(input logic [8:0] din, input logic dv, input logic st,
                        input logic hf, input logic fl,
                        output logic rdy_o, output logic crdy_o);
      d = din; d_valid = dv; stall = st; enable_half = hf; flush = fl;
      #1;
      rdy_o  = d_ready;
      crdy_o = c_d_ready;
      if (fl) begin
         sb.delete();
      end else begin
         if (q_valid && !st && !hf) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else                check("sb_q", 32'(q), 32'(sb.pop_front()));
         end
         if (d_ready && dv) sb.push_back(din);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; enable_half = 1'b0; stall = 1'b0; flush = 1'b0;
      d = '0; d_valid = 1'b0;

      // Reset state
      #12;
      check("rst_q",       32'(q),         32'h000);
      check("rst_q_valid", 32'(q_valid),   32'd0);
      check("rst_occ",     32'(occupancy), 32'd0);
      check("rst_d_ready", 32'(d_ready),   32'd0);
      reset_n = 1'b1;

      // Pass-through: 0x001..0x005, three-edge latency
      for (int k = 1; k <= 5; k++) begin
         cycle(9'(k), 1'b1, 1'b0, 1'b0, 1'b0, rdy, crdy);
         check("pt_ready", 32'(rdy), 32'd1);
         if (k == 1) check("pt_occ1", 32'(occupancy), 32'd1);
         if (k == 2) check("pt_qv_early", 32'(q_valid), 32'd0);
         if (k >= 3) begin
            check("pt_q",  32'(q),       32'(k - 2));
            check("pt_qv", 32'(q_valid), 32'd1);
         end
      end
      check("pt_occ_end", 32'(occupancy), 32'd3);

      // Fill with 0x010..0x012, then stall for four cycles
      for (int k = 0; k < 3; k++) cycle(9'h010 + 9'(k), 1'b1, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("fill_q", 32'(q), 32'h010);
      for (int k = 0; k < 4; k++) begin
         cycle(9'h013, 1'b1, 1'b1, 1'b0, 1'b0, rdy, crdy);
         check("stall_ready", 32'(rdy),       32'd0);
         check("stall_q",     32'(q),         32'h010);
         check("stall_occ",   32'(occupancy), 32'd3);
      end
      cycle(9'h013, 1'b1, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("unstall_ready", 32'(rdy), 32'd1);
      check("unstall_q",     32'(q),   32'h011);

      // Flush with stall and a valid input on the same cycle
      cycle(9'h0EE, 1'b1, 1'b1, 1'b0, 1'b1, rdy, crdy);
      check("flush_ready", 32'(rdy),       32'd0);
      check("flush_qv",    32'(q_valid),   32'd0);
      check("flush_occ",   32'(occupancy), 32'd0);
      check("flush_q",     32'(q),         32'h000);
      cycle(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("post_flush_occ", 32'(occupancy), 32'd0);

      // Half rate: hold on odd cycles, data changes every advancing cycle
      for (int j = 0; j < 12; j++) begin
         cycle(9'h100 + 9'(j / 2), 1'b1, 1'b0, 1'(j % 2), 1'b0, rdy, crdy);
         check("half_ready", 32'(rdy), 32'((j % 2) == 0));
         check("half_occ", 32'(occupancy), 32'((j / 2 + 1) < 3 ? (j / 2 + 1) : 3));
         if (j < 4) begin
            check("half_qv_early", 32'(q_valid), 32'd0);
         end else begin
            check("half_qv", 32'(q_valid), 32'd1);
            check("half_q",  32'(q),       32'h100 + 32'((j - 4) / 2));
         end
      end

      // Asynchronous reset between edges with the pipe full
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_q",     32'(q),         32'h000);
      check("arst_qv",    32'(q_valid),   32'd0);
      check("arst_occ",   32'(occupancy), 32'd0);
      check("arst_ready", 32'(d_ready),   32'd0);
      sb.delete();
      #2;
      reset_n = 1'b1;
      d_valid = 1'b0; enable_half = 1'b0; stall = 1'b0;
      @(posedge clk);
      #1;
      check("arst_after_qv", 32'(q_valid), 32'd0);

      // Bubble collapse on the COLLAPSE=1 instance: build {s0,s1,s2} valid = {1,0,1}
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      sb.delete();
      cycle(9'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, rdy, crdy);
      cycle(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, rdy, crdy);
      cycle(9'h0CC, 1'b1, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("col_pre_q",   32'(c_q),         32'h0AA);
      check("col_pre_occ", 32'(c_occupancy), 32'd2);
      cycle(9'h0BB, 1'b1, 1'b1, 1'b0, 1'b0, rdy, crdy);
      check("col_ready",    32'(crdy),        32'd1);
      check("col_stall_q",  32'(c_q),         32'h0AA);
      check("col_stall_qv", 32'(c_q_valid),   32'd1);
      check("col_occ",      32'(c_occupancy), 32'd3);
      cycle(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("col_drain1", 32'(c_q), 32'h0CC);
      cycle(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("col_drain2",     32'(c_q),         32'h0BB);
      check("col_drain2_occ", 32'(c_occupancy), 32'd1);
      cycle(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, rdy, crdy);
      check("col_empty_qv",  32'(c_q_valid),   32'd0);
      check("col_empty_occ", 32'(c_occupancy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_flopr_pipe
